// File: rtl/fpu_pkg.sv
// Shared constants and state encoding for the FPU operand-port arbiter.
package fpu_pkg;

    localparam int unsigned REQ_NUM   = 4;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned OPERAND_W = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux_4_to_1.sv
// Plain 4-way N-bit multiplexer; S selects A (0) through D (3).
module mux_4_to_1 #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic [1:0]   S,
    output logic [N-1:0] Y
);

    always_comb begin
        unique case (S)
            2'd0: Y = A;
            2'd1: Y = B;
            2'd2: Y = C;
            2'd3: Y = D;
        endcase
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Four-requester arbiter feeding one registered FPU operand stage.
// Define FPU_ARB_RR_EN for round-robin; otherwise fixed priority (A highest).
module fpu_req_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned N = OPERAND_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [N-1:0] in_data_a,
    input  logic [N-1:0] in_data_b,
    input  logic [N-1:0] in_data_c,
    input  logic [N-1:0] in_data_d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   out_id
);

    arb_state_e          state_q, state_d;
    logic [N-1:0]        data_q, data_d;
    logic [N-1:0]        mux_y;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     prio_ptr;
    logic [REQ_NUM-1:0]  grant;
    logic                stage_free;
    logic                accept;

`ifdef FPU_ARB_RR_EN
    logic [ID_W-1:0] prio_ptr_q, prio_ptr_d;

    always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (accept) begin
            prio_ptr_d = grant_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ptr_q <= '0;
        end else begin
            prio_ptr_q <= prio_ptr_d;
        end
    end

    assign prio_ptr = prio_ptr_q;
`else
    assign prio_ptr = '0;
`endif

    // Circular search for the first valid requester starting at prio_ptr.
    always_comb begin
        logic [ID_W-1:0] idx;
        logic            found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = prio_ptr + ID_W'(k);
            if (!found && in_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    assign stage_free = (state_q == ST_EMPTY) || out_ready;
    assign accept     = (|grant) && stage_free;
    assign in_ready   = grant & {REQ_NUM{stage_free}};

    mux_4_to_1 #(
        .N (N)
    ) u_mux (
        .A (in_data_a),
        .B (in_data_b),
        .C (in_data_c),
        .D (in_data_d),
        .S (grant_idx),
        .Y (mux_y)
    );

    // A drain and a reload in the same cycle keep the stage full with no bubble.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        if (accept) begin
            state_d = ST_FULL;
            data_d  = mux_y;
            id_d    = grant_idx;
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed self-checking bench for fpu_req_arbiter; expectations follow FPU_ARB_RR_EN.
module tb_fpu_req_arbiter;

`ifdef FPU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data_a, in_data_b, in_data_c, in_data_d;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_id;

    int vectors;
    int miscompares;

    logic [31:0] lane [4];

    fpu_req_arbiter #(
        .N (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data_a (in_data_a),
        .in_data_b (in_data_b),
        .in_data_c (in_data_c),
        .in_data_d (in_data_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_lanes(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
        lane[0] = a; lane[1] = b; lane[2] = c; lane[3] = d;
        in_data_a = a; in_data_b = b; in_data_c = c; in_data_d = d;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 4'b0000; out_ready = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 4'b0000; out_ready = 1'b0;
        load_lanes(32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        vectors++;
        if (out_data !== 32'h0) begin
            miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        vectors++;
        if (out_id !== 2'd0) begin
            miscompares++; $display("FAIL reset_out_id: got %0d want 0", out_id);
        end
        vectors++;
        if (in_ready !== 4'b0000) begin
            miscompares++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Load B with the FPU stalled so the stage is full when reset hits.
        @(negedge clk);
        load_lanes(32'hA0A0_0000, 32'h1111_1111, 32'hC0C0_0000, 32'hD0D0_0000);
        in_valid = 4'b0010;
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL preload_b: got v=%b id=%0d d=%h want v=1 id=1 d=11111111",
                     out_valid, out_id, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_id !== 2'd0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b id=%0d d=%h want v=0 id=0 d=0",
                     out_valid, out_id, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0001) begin
            miscompares++; $display("FAIL post_reset_grant: got %b want 0001", in_ready);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 32'hA0A0_0000) begin
            miscompares++;
            $display("FAIL post_reset_word: got v=%b id=%0d d=%h want v=1 id=0 d=a0a00000",
                     out_valid, out_id, out_data);
        end
    endtask

    task automatic test_single();
        reset_dut();
        @(negedge clk);
        load_lanes(32'h1234_5678, 32'h9ABC_DEF0, 32'h3F80_0000, 32'h0BAD_F00D);
        in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0100 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ready: got rdy=%b v=%b want rdy=0100 v=0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000 || out_id !== 2'd2) begin
            miscompares++;
            $display("FAIL single_word: got v=%b id=%0d d=%h want v=1 id=2 d=3f800000",
                     out_valid, out_id, out_data);
        end
        vectors++;
        if (in_ready !== 4'b0000) begin
            miscompares++; $display("FAIL single_idle_ready: got %b want 0000", in_ready);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_drain: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        int exp_id;
        int prev_id;
        reset_dut();
        @(negedge clk);
        load_lanes(32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004);
        in_valid = 4'b1111; out_ready = 1'b1;
        prev_id = 0;
        for (int k = 0; k < 8; k++) begin
            exp_id = RR ? (k % 4) : 0;
            #1;
            vectors++;
            if (in_ready !== 4'(1 << exp_id)) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: got %b want %b", k, in_ready, 4'(1 << exp_id));
            end
            if (k > 0) begin
                vectors++;
                if (out_valid !== 1'b1 || out_id !== 2'(prev_id) || out_data !== lane[prev_id]) begin
                    miscompares++;
                    $display("FAIL rr_word[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                             k, out_valid, out_id, out_data, prev_id, lane[prev_id]);
                end
            end
            prev_id = exp_id;
            @(negedge clk);
        end
        in_valid = 4'b0000;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'(prev_id) || out_data !== lane[prev_id]) begin
            miscompares++;
            $display("FAIL rr_last: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                     out_valid, out_id, out_data, prev_id, lane[prev_id]);
        end
    endtask

    task automatic test_back_pressure();
        reset_dut();
        @(negedge clk);
        load_lanes(32'h4049_0FDB, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000);
        in_valid = 4'b0001; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_id !== 2'd0
                || out_data !== 32'h4049_0FDB) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%0d d=%h want 0000 1 0 40490fdb",
                         k, in_ready, out_valid, out_id, out_data);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0010) begin
            miscompares++; $display("FAIL bp_release_grant: got %b want 0010", in_ready);
        end
        @(negedge clk);
        in_valid = 4'b0100;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 32'h4000_0000) begin
            miscompares++;
            $display("FAIL bp_reload: got v=%b id=%0d d=%h want v=1 id=1 d=40000000",
                     out_valid, out_id, out_data);
        end
        vectors++;
        if (in_ready !== 4'b0100) begin
            miscompares++; $display("FAIL bp_next_grant: got %b want 0100", in_ready);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 32'h4040_0000) begin
            miscompares++;
            $display("FAIL bp_second: got v=%b id=%0d d=%h want v=1 id=2 d=40400000",
                     out_valid, out_id, out_data);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_rdy;
        int         exp_id;
        reset_dut();
        @(negedge clk);
        load_lanes(32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3, 32'h0000_00D4);
        in_valid = 4'b1000; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b1000) begin
            miscompares++; $display("FAIL wrap_d_first: got %b want 1000", in_ready);
        end
        @(negedge clk);
        in_valid = 4'b1001;
        #1;
        vectors++;
        if (in_ready !== 4'b0001 || out_id !== 2'd3) begin
            miscompares++;
            $display("FAIL wrap_a_grant: got rdy=%b id=%0d want rdy=0001 id=3", in_ready, out_id);
        end
        // A re-requests immediately: round-robin must now prefer D.
        @(negedge clk);
        exp_rdy = RR ? 4'b1000 : 4'b0001;
        exp_id  = RR ? 3 : 0;
        #1;
        vectors++;
        if (in_ready !== exp_rdy || out_id !== 2'd0 || out_data !== 32'h0000_00A1) begin
            miscompares++;
            $display("FAIL wrap_next: got rdy=%b id=%0d d=%h want rdy=%b id=0 d=000000a1",
                     in_ready, out_id, out_data, exp_rdy);
        end
        @(negedge clk);
        in_valid = 4'b0000;
        #1;
        vectors++;
        if (out_id !== 2'(exp_id) || out_data !== lane[exp_id]) begin
            miscompares++;
            $display("FAIL wrap_word: got id=%0d d=%h want id=%0d d=%h",
                     out_id, out_data, exp_id, lane[exp_id]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
